// File: rtl/dcache_pkg.sv
// Shared constants for the direct-mapped data cache controller:
// FSM state encoding, line/word widths and address field boundaries.
package dcache_pkg;

    localparam int LINE_W   = 128;
    localparam int WORD_W   = 32;
    localparam int STRB_W   = WORD_W / 8;

    // Address fields: offset [3:0], word select [3:2], index [9:4], tag [31:10]
    localparam int OFF_MSB  = 3;
    localparam int WSEL_LSB = 2;
    localparam int IDX_LSB  = 4;
    localparam int IDX_MSB  = 9;
    localparam int TAG_LSB  = 10;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_WB_REQ  = 3'd2;
    localparam logic [2:0] S_WB_WAIT = 3'd3;
    localparam logic [2:0] S_RF_REQ  = 3'd4;
    localparam logic [2:0] S_RF_WAIT = 3'd5;
    localparam logic [2:0] S_FILL    = 3'd6;
    localparam logic [2:0] S_RESP    = 3'd7;

endpackage

// File: rtl/dcache_merge.sv
// Merges a strobed 32-bit store word into a 128-bit line and produces the
// matching active-low bit write mask for the line store.
module dcache_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [1:0]        word_sel,
    input  logic [WORD_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [LINE_W-1:0] merged,
    output logic [LINE_W-1:0] bwen
);

    always_comb begin
        merged = line;
        bwen   = '1;
        for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) begin
                merged[{word_sel, 5'b0} + 7'(b * 8) +: 8] = wdata[b*8 +: 8];
                bwen[{word_sel, 5'b0} + 7'(b * 8) +: 8]   = '0;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back/write-allocate data cache controller driving an
// SRAM-style line/flag store and a 128-bit line memory port.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int TAG_LEN  = DATA_LEN - 10,
    parameter int ADDR_LEN = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_LEN-1:0] req_addr,
    input  logic                req_wen,
    input  logic [WORD_W-1:0]   req_wdata,
    input  logic [STRB_W-1:0]   req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORD_W-1:0]   rsp_rdata,
    output logic                line_CEN,
    output logic                line_WEN,
    output logic [LINE_W-1:0]   line_BWEN,
    output logic [ADDR_LEN-1:0] line_A,
    output logic [LINE_W-1:0]   line_D,
    input  logic [LINE_W-1:0]   line_Q,
    output logic [TAG_LEN-1:0]  line_tag_in,
    output logic                line_dirty_flag,
    input  logic [TAG_LEN-1:0]  line_tag,
    input  logic                line_valid,
    input  logic                line_dirty,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [DATA_LEN-1:0] mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic                mem_rvalid,
    input  logic [LINE_W-1:0]   mem_rdata
);

    logic [2:0]                state;
    logic [DATA_LEN-1:2]       addr_q;
    logic                      wen_q;
    logic [WORD_W-1:0]         wdata_q;
    logic [STRB_W-1:0]         wstrb_q;
    logic [LINE_W-1:0]         line_buf;
    logic [TAG_LEN-1:0]        victim_tag;

    logic [ADDR_LEN-1:0]       req_idx;
    logic [TAG_LEN-1:0]        req_tag;
    logic [1:0]                word_sel;
    logic                      hit;
    logic [WORD_W-1:0]         q_word;
    logic [WORD_W-1:0]         fill_word;
    logic [LINE_W-1:0]         merge_src;
    logic [LINE_W-1:0]         merged_line;
    logic [LINE_W-1:0]         merge_bwen;
    logic                      req_addr_unused;

    assign req_idx         = addr_q[IDX_MSB:IDX_LSB];
    assign req_tag         = addr_q[DATA_LEN-1:TAG_LSB];
    assign word_sel        = addr_q[OFF_MSB:WSEL_LSB];
    assign hit             = line_valid && (line_tag == req_tag);
    assign q_word          = line_Q[{word_sel, 5'b0} +: WORD_W];
    assign fill_word       = line_buf[{word_sel, 5'b0} +: WORD_W];
    assign req_addr_unused = ^req_addr[1:0];

    // Store hits merge into the looked-up line, fills merge into the refill.
    assign merge_src = (state == S_FILL) ? line_buf : line_Q;

    dcache_merge u_merge (
        .line     (merge_src),
        .word_sel (word_sel),
        .wdata    (wdata_q),
        .wstrb    (wstrb_q),
        .merged   (merged_line),
        .bwen     (merge_bwen)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            line_buf   <= '0;
            victim_tag <= '0;
            rsp_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[DATA_LEN-1:2];
                        wen_q   <= req_wen;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        rsp_rdata <= wen_q ? '0 : q_word;
                        state     <= S_RESP;
                    end else begin
                        line_buf   <= line_Q;
                        victim_tag <= line_tag;
                        state      <= (line_valid && line_dirty) ? S_WB_REQ : S_RF_REQ;
                    end
                end
                S_WB_REQ:  if (mem_ready)  state <= S_WB_WAIT;
                S_WB_WAIT: if (mem_rvalid) state <= S_RF_REQ;
                S_RF_REQ:  if (mem_ready)  state <= S_RF_WAIT;
                S_RF_WAIT: begin
                    if (mem_rvalid) begin
                        line_buf <= mem_rdata;
                        state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    rsp_rdata <= wen_q ? '0 : fill_word;
                    state     <= S_RESP;
                end
                S_RESP:    if (rsp_ready)  state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Line store and memory port are decoded straight from the state so a
    // stalled request keeps every field stable.
    always_comb begin
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        line_CEN        = 1'b1;
        line_WEN        = 1'b1;
        line_BWEN       = '1;
        line_A          = '0;
        line_D          = '0;
        line_tag_in     = '0;
        line_dirty_flag = 1'b0;
        mem_valid       = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    line_CEN = 1'b0;
                    line_A   = req_addr[IDX_MSB:IDX_LSB];
                end
            end
            S_LOOKUP: begin
                line_A = req_idx;
                if (hit && wen_q) begin
                    line_CEN        = 1'b0;
                    line_WEN        = 1'b0;
                    line_BWEN       = merge_bwen;
                    line_D          = {4{wdata_q}};
                    line_tag_in     = req_tag;
                    line_dirty_flag = 1'b1;
                end
            end
            S_WB_REQ: begin
                line_A    = req_idx;
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {victim_tag, req_idx, 4'b0};
                mem_wdata = line_buf;
            end
            S_RF_REQ: begin
                line_A    = req_idx;
                mem_valid = 1'b1;
                mem_addr  = {req_tag, req_idx, 4'b0};
            end
            S_FILL: begin
                line_CEN        = 1'b0;
                line_WEN        = 1'b0;
                line_BWEN       = '0;
                line_A          = req_idx;
                line_D          = wen_q ? merged_line : line_buf;
                line_tag_in     = req_tag;
                line_dirty_flag = wen_q;
            end
            S_RESP: begin
                line_A    = req_idx;
                rsp_valid = 1'b1;
            end
            default: line_A = req_idx;
        endcase
    end

endmodule
